// File: rtl/mem_tile_sram_sched.sv
`default_nettype none
// ============================================================================
// Module   : mem_tile_sram_sched
// Purpose  : Shares one single-ported, 1-cycle-latency SRAM interface between
//            NumReq OBI-style requesters with round-robin arbitration. An
//            initialisation sequence zero-fills every SRAM word after reset
//            (when InitOnReset=1) or on an init_req_i pulse, before any
//            requester is granted.
// Ports    : clk_i/rst_ni          clock, async active-low reset
//            req/we/addr/wdata/be  packed per-requester OBI request fields
//            gnt_o                 one-hot combinational grant
//            rvalid_o/rdata_o      response one cycle after grant, shared data
//            mem_*                 SRAM macro interface
//            init_req_i            pulse: re-run zero-fill (ignored in INIT)
//            init_done_o           high while in RUN
//            busy_o                SRAM request or response pending
// Revision : 1.0 - initial release
// ============================================================================
module mem_tile_sram_sched #(
  parameter int unsigned NumReq      = 2,
  parameter int unsigned AddrWidth   = 48,
  parameter int unsigned DataWidth   = 512,
  parameter int unsigned NumWords    = 8192,
  parameter bit          InitOnReset = 1'b1
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NumReq-1:0]               req_i,
  input  logic [NumReq-1:0]               we_i,
  input  logic [NumReq*AddrWidth-1:0]     addr_i,
  input  logic [NumReq*DataWidth-1:0]     wdata_i,
  input  logic [NumReq*DataWidth/8-1:0]   be_i,
  output logic [NumReq-1:0]               gnt_o,
  output logic [NumReq-1:0]               rvalid_o,
  output logic [DataWidth-1:0]            rdata_o,
  output logic                            mem_req_o,
  output logic                            mem_we_o,
  output logic [AddrWidth-1:0]            mem_addr_o,
  output logic [DataWidth-1:0]            mem_wdata_o,
  output logic [DataWidth/8-1:0]          mem_be_o,
  input  logic [DataWidth-1:0]            mem_rdata_i,
  input  logic                            init_req_i,
  output logic                            init_done_o,
  output logic                            busy_o
);

  localparam int unsigned c_be_width  = DataWidth / 8;
  localparam int unsigned c_addr_lsb  = $clog2(c_be_width);
  localparam int unsigned c_cnt_width = (NumWords > 1) ? $clog2(NumWords) : 1;
  localparam int unsigned c_ptr_width = $clog2(NumReq);

  localparam logic [c_cnt_width-1:0] c_cnt_last = c_cnt_width'(NumWords - 1);
  localparam logic [c_ptr_width-1:0] c_ptr_last = c_ptr_width'(NumReq - 1);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam state_t c_reset_state = InitOnReset ? ST_INIT : ST_RUN;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [c_cnt_width-1:0]  r_cnt;
  logic [c_cnt_width-1:0]  w_cnt_next;
  logic [c_ptr_width-1:0]  r_ptr;
  logic [c_ptr_width-1:0]  w_ptr_next;
  logic [NumReq-1:0]       r_rvalid;

  logic                    w_found;
  logic [c_ptr_width-1:0]  w_winner;
  logic [NumReq-1:0]       w_gnt;
  logic [AddrWidth-1:0]    w_init_addr;

  // (ptr + k) reduced modulo NumReq; the sum is always below 2*NumReq so a
  // single conditional subtract suffices, and NumReq need not be a power of 2.
  function automatic logic [c_ptr_width-1:0] f_wrap(input logic [c_ptr_width:0] v);
    logic [c_ptr_width:0] t;
    t = v;
    if (t >= (c_ptr_width+1)'(NumReq)) t = t - (c_ptr_width+1)'(NumReq);
    return t[c_ptr_width-1:0];
  endfunction

  // Round-robin search: first asserted request at or after the pointer.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      logic [c_ptr_width-1:0] idx;
      idx = f_wrap({1'b0, r_ptr} + (c_ptr_width+1)'(k));
      if (!w_found && req_i[idx]) begin
        w_found  = 1'b1;
        w_winner = idx;
      end
    end
  end

  assign w_init_addr = AddrWidth'(r_cnt) << c_addr_lsb;

  // Next-state and output logic.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_ptr_next   = r_ptr;
    w_gnt        = '0;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    mem_be_o     = '0;

    case (r_state)
      ST_INIT: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = w_init_addr;
        mem_be_o    = '1;
        if (r_cnt == c_cnt_last) begin
          w_cnt_next   = '0;
          w_state_next = ST_RUN;
        end else begin
          w_cnt_next = r_cnt + c_cnt_width'(1);
        end
      end
      default: begin
        mem_req_o   = |req_i;
        mem_we_o    = we_i[w_winner];
        mem_addr_o  = addr_i[w_winner*AddrWidth +: AddrWidth];
        mem_wdata_o = wdata_i[w_winner*DataWidth +: DataWidth];
        mem_be_o    = be_i[w_winner*c_be_width +: c_be_width];
        if (w_found) begin
          w_gnt[w_winner] = 1'b1;
          w_ptr_next      = (w_winner == c_ptr_last) ? '0 : w_winner + c_ptr_width'(1);
        end
        // This cycle's grant still completes; zero-fill starts next cycle.
        if (init_req_i) begin
          w_state_next = ST_INIT;
          w_cnt_next   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= c_reset_state;
      r_cnt    <= '0;
      r_ptr    <= '0;
      r_rvalid <= '0;
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_ptr    <= w_ptr_next;
      r_rvalid <= w_gnt;
    end
  end

  assign gnt_o       = w_gnt;
  assign rvalid_o    = r_rvalid;
  // The SRAM returns the previous cycle's read, so an rvalid delivered in the
  // first INIT cycle still sees the correct data here.
  assign rdata_o     = mem_rdata_i;
  assign init_done_o = (r_state == ST_RUN);
  assign busy_o      = mem_req_o | (|r_rvalid);

endmodule
`default_nettype wire

// File: tb/tb_mem_tile_sram_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_tile_sram_sched
// Purpose  : Self-checking bench for mem_tile_sram_sched (NumWords=16). A
//            behavioural SRAM answers the DUT; a transaction-level model
//            predicts grants, responses and memory contents.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_tile_sram_sched;

  localparam int NR = 2;
  localparam int AW = 48;
  localparam int DW = 512;
  localparam int NW = 16;
  localparam int BW = DW / 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [NR-1:0] req, we;
  logic [AW-1:0] a_addr  [NR];
  logic [DW-1:0] a_wdata [NR];
  logic [BW-1:0] a_be    [NR];
  logic          init_req;

  logic [NR-1:0] gnt, rvalid;
  logic [DW-1:0] rdata, mem_wdata, mem_rdata;
  logic          mem_req, mem_we, init_done, busy;
  logic [AW-1:0] mem_addr;
  logic [BW-1:0] mem_be;

  mem_tile_sram_sched #(
    .NumReq(NR), .AddrWidth(AW), .DataWidth(DW), .NumWords(NW), .InitOnReset(1'b1)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we),
    .addr_i({a_addr[1], a_addr[0]}), .wdata_i({a_wdata[1], a_wdata[0]}),
    .be_i({a_be[1], a_be[0]}), .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_be_o(mem_be), .mem_rdata_i(mem_rdata),
    .init_req_i(init_req), .init_done_o(init_done), .busy_o(busy)
  );

  // Second instance: no initialisation after reset.
  logic [NR-1:0]    b_req, b_we, b_gnt, b_rvalid;
  logic [NR*AW-1:0] b_addr;
  logic [NR*DW-1:0] b_wdata;
  logic [NR*BW-1:0] b_be;
  logic [DW-1:0]    b_rdata, b_mem_wdata, b_mem_rdata;
  logic             b_mem_req, b_mem_we, b_init_req, b_init_done, b_busy;
  logic [AW-1:0]    b_mem_addr;
  logic [BW-1:0]    b_mem_be;

  mem_tile_sram_sched #(
    .NumReq(NR), .AddrWidth(AW), .DataWidth(DW), .NumWords(NW), .InitOnReset(1'b0)
  ) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .req_i(b_req), .we_i(b_we), .addr_i(b_addr),
    .wdata_i(b_wdata), .be_i(b_be), .gnt_o(b_gnt), .rvalid_o(b_rvalid),
    .rdata_o(b_rdata), .mem_req_o(b_mem_req), .mem_we_o(b_mem_we),
    .mem_addr_o(b_mem_addr), .mem_wdata_o(b_mem_wdata), .mem_be_o(b_mem_be),
    .mem_rdata_i(b_mem_rdata), .init_req_i(b_init_req),
    .init_done_o(b_init_done), .busy_o(b_busy)
  );

  // Behavioural single-port SRAM, 1-cycle read latency.
  logic [DW-1:0] sram [NW];
  always @(posedge clk) begin
    if (rst_n && mem_req) begin
      if (mem_we) begin
        for (int b = 0; b < BW; b++)
          if (mem_be[b]) sram[mem_addr[9:6]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= sram[mem_addr[9:6]];
      end
    end
  end

  // Reference model state.
  bit            m_init;
  int            m_cnt, m_ptr;
  logic [NR-1:0] m_rv;
  bit            m_rv_rd;
  logic [DW-1:0] m_rv_data;
  logic [DW-1:0] ref_mem [NW];

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_init = 1'b1; m_cnt = 0; m_ptr = 0; m_rv = '0; m_rv_rd = 1'b0; m_rv_data = '0;
  endtask

  task automatic chk_reset_a();
    chk("rst_gnt", gnt, '0);
    chk("rst_mem_req", mem_req, 1'b1);
    chk("rst_mem_addr", mem_addr, '0);
    chk("rst_rvalid", rvalid, '0);
    chk("rst_init_done", init_done, 1'b0);
  endtask

  // One clock cycle: entered at a falling edge with inputs applied; checks
  // outputs against the model, advances the model, ends at next falling edge.
  task automatic cycle();
    logic [NR-1:0] eg;
    logic          ereq;
    bit            found;
    int            w;
    logic [3:0]    word;
    #1;
    eg = '0; found = 1'b0; w = 0;
    if (!m_init) begin
      for (int k = 0; k < NR; k++) begin
        int i;
        i = (m_ptr + k) % NR;
        if (!found && req[i]) begin found = 1'b1; w = i; end
      end
    end
    if (found) eg[w] = 1'b1;
    ereq = m_init ? 1'b1 : |req;

    chk("gnt", gnt, eg);
    chk("mem_req", mem_req, ereq);
    chk("init_done", init_done, !m_init);
    chk("rvalid", rvalid, m_rv);
    chk("busy", busy, ereq | (|m_rv));
    if (m_init) begin
      chk("init_we", mem_we, 1'b1);
      chk("init_addr", mem_addr, m_cnt * 64);
      chk("init_wdata", mem_wdata, '0);
      chk("init_be", mem_be, {BW{1'b1}});
    end else if (found) begin
      chk("mem_we", mem_we, we[w]);
      chk("mem_addr", mem_addr, a_addr[w]);
      if (we[w]) begin
        chk("mem_wdata", mem_wdata, a_wdata[w]);
        chk("mem_be", mem_be, a_be[w]);
      end
    end
    if (m_rv != '0 && m_rv_rd) chk("rdata", rdata, m_rv_data);

    m_rv    = eg;
    m_rv_rd = found && !we[w];
    if (found) begin
      word      = a_addr[w][9:6];
      m_rv_data = ref_mem[word];
      if (we[w])
        for (int b = 0; b < BW; b++)
          if (a_be[w][b]) ref_mem[word][8*b +: 8] = a_wdata[w][8*b +: 8];
      m_ptr = (w + 1) % NR;
    end
    if (m_init) begin
      ref_mem[m_cnt] = '0;
      m_cnt++;
      if (m_cnt == NW) begin m_cnt = 0; m_init = 1'b0; end
    end else if (init_req) begin
      m_init = 1'b1; m_cnt = 0;
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; init_req = 1'b0; req = 2'b11; we = 2'b00;
    for (int i = 0; i < NR; i++) begin
      a_addr[i] = AW'((i + 1) * 64); a_wdata[i] = '0; a_be[i] = '1;
    end
    b_req = '0; b_we = '0; b_addr = '0; b_wdata = '0; b_be = '1;
    b_init_req = 1'b0; b_mem_rdata = '0; mem_rdata = '0;
    for (int i = 0; i < NW; i++) begin
      sram[i]    = {16{32'hA5A5_5A5A}};
      ref_mem[i] = {16{32'hA5A5_5A5A}};
    end
    model_reset();

    // Reset values of both instances.
    repeat (2) @(negedge clk);
    #1;
    chk_reset_a();
    chk("rst_busy", busy, 1'b1);
    chk("b_rst_init_done", b_init_done, 1'b1);
    chk("b_rst_mem_req", b_mem_req, 1'b0);
    chk("b_rst_gnt", b_gnt, '0);
    chk("b_rst_busy", b_busy, 1'b0);

    // Release; instance B is granted in its first cycle.
    rst_n = 1'b1;
    b_req = 2'b01;
    #1;
    chk("b_first_gnt", b_gnt, 2'b01);
    chk("b_first_mem_req", b_mem_req, 1'b1);
    cycle();
    chk("b_rvalid", b_rvalid, 2'b01);
    b_req = 2'b00;
    #1;
    chk("b_idle_mem_req", b_mem_req, 1'b0);
    chk("b_idle_gnt", b_gnt, '0);

    // Initial zero-fill with both requests held, then alternation.
    repeat (NW - 1) cycle();
    repeat (4) cycle();

    // Requester 1 writes 0xDEAD to word 5, requester 0 reads it back.
    req = 2'b10; we = 2'b10; a_addr[1] = AW'(5 * 64);
    a_wdata[1] = DW'(32'hDEAD); a_be[1] = '1;
    cycle();
    req = 2'b01; we = 2'b00; a_addr[0] = AW'(5 * 64);
    cycle();
    a_addr[0] = AW'(3 * 64);
    cycle();
    req = 2'b00;
    cycle();

    // init_req in the same cycle as a read grant to requester 1.
    req = 2'b11; we = 2'b00; a_addr[1] = AW'(5 * 64); a_addr[0] = AW'(7 * 64);
    init_req = 1'b1;
    cycle();
    init_req = 1'b0;
    repeat (NW) cycle();
    cycle();
    req = 2'b00;
    cycle();

    // Reset asserted in the 7th INIT cycle, then a full restart.
    init_req = 1'b1;
    cycle();
    init_req = 1'b0; req = 2'b01;
    repeat (6) cycle();
    rst_n = 1'b0;
    #1;
    chk_reset_a();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (NW + 2) cycle();

    // Randomised traffic against the model.
    repeat (300) begin
      req = NR'($urandom_range(0, 3));
      we  = NR'($urandom_range(0, 3));
      for (int i = 0; i < NR; i++) begin
        a_addr[i] = AW'($urandom_range(0, NW - 1) * 64);
        for (int j = 0; j < DW / 32; j++) a_wdata[i][32*j +: 32] = $urandom();
        a_be[i] = ($urandom_range(0, 1) == 0) ? '1 : {$urandom(), $urandom()};
      end
      init_req = ($urandom_range(0, 49) == 0);
      cycle();
    end
    req = 2'b00; init_req = 1'b0;
    repeat (2) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
